trap_sequencer: RTL and testbench

//  Writeback-stage trap/return controller; the driving side of the CSR file's write, trap and interrupt interface.

---
 rtl/trap_sequencer.sv | 165 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Writeback-stage trap/return controller: detects exceptions, interrupts and MRET,
// then sequences mepc/mcause/mtval CSR writes and the fetch redirect. Optional macro: TRAP_VECTORED_EN.
module trap_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_next_pc,
  input  logic        wb_exception,
  input  logic [3:0]  wb_cause,
  input  logic [31:0] wb_tval,
  input  logic        wb_mret,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic        retired,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_target
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_REDIR
  } state_t;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  state_t      r_state;
  logic [31:0] r_ecp;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic        r_csr_we;
  logic [11:0] r_csr_addr;
  logic [31:0] r_csr_data;
  logic        r_traped;
  logic        r_trap_redir;
  logic [31:0] r_redirect_target;

  logic        w_idle;
  logic        w_any_irq;
  logic        w_take_exc;
  logic        w_take_mret;
  logic        w_take_irq;
  logic [31:0] w_irq_cause;
  logic [31:0] w_cap_epc;
  logic [31:0] w_cap_cause;
  logic [31:0] w_cap_tval;
  logic [31:0] w_trap_base;
  logic [31:0] w_trap_target;

  // Event decode only happens in IDLE; exception beats MRET beats interrupt.
  assign w_idle      = (r_state == S_IDLE);
  assign w_any_irq   = eip | tip | sip;
  assign w_take_exc  = w_idle & wb_valid & wb_exception;
  assign w_take_mret = w_idle & wb_valid & ~wb_exception & wb_mret;
  assign w_take_irq  = w_idle & wb_valid & ~wb_exception & ~wb_mret & w_any_irq;

  assign w_irq_cause = eip ? 32'h8000_000B :
                       sip ? 32'h8000_0003 :
                             32'h8000_0007;

  assign w_cap_epc   = w_take_exc ? wb_pc : wb_next_pc;
  assign w_cap_cause = w_take_exc ? {1'b0, 27'b0, wb_cause} : w_irq_cause;
  assign w_cap_tval  = w_take_exc ? wb_tval : 32'h0000_0000;

  assign w_trap_base = {trap_vector[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Only interrupt causes (bit 31 set) are vectored; exceptions land on the base.
  assign w_trap_target = (r_cause[31] && (trap_vector[1:0] == 2'b01)) ?
                         (w_trap_base + {26'b0, r_cause[3:0], 2'b00}) :
                         w_trap_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = &{1'b0, trap_vector[1:0]};
  assign w_trap_target = w_trap_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_ecp             <= 32'h0000_0000;
      r_cause           <= 32'h0000_0000;
      r_tval            <= 32'h0000_0000;
      r_csr_we          <= 1'b0;
      r_csr_addr        <= 12'h000;
      r_csr_data        <= 32'h0000_0000;
      r_traped          <= 1'b0;
      r_trap_redir      <= 1'b0;
      r_redirect_target <= RESET_VECTOR;
    end else begin
      r_csr_we     <= 1'b0;
      r_traped     <= 1'b0;
      r_trap_redir <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_exc || w_take_irq) begin
            r_ecp      <= w_cap_epc;
            r_cause    <= w_cap_cause;
            r_tval     <= w_cap_tval;
            r_csr_we   <= 1'b1;
            r_csr_addr <= CSR_MEPC;
            r_csr_data <= w_cap_epc;
            r_state    <= S_W_EPC;
          end
        end
        S_W_EPC: begin
          r_csr_we   <= 1'b1;
          r_csr_addr <= CSR_MCAUSE;
          r_csr_data <= r_cause;
          r_state    <= S_W_CAUSE;
        end
        S_W_CAUSE: begin
          r_csr_we   <= 1'b1;
          r_csr_addr <= CSR_MTVAL;
          r_csr_data <= r_tval;
          r_state    <= S_W_TVAL;
        end
        S_W_TVAL: begin
          r_traped          <= 1'b1;
          r_trap_redir      <= 1'b1;
          r_redirect_target <= w_trap_target;
          r_state           <= S_REDIR;
        end
        S_REDIR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // MRET completes in its own IDLE cycle, so its strobes bypass the registers.
  assign csr_write_enable  = r_csr_we;
  assign csr_write_address = r_csr_addr;
  assign csr_write_data    = r_csr_data;
  assign traped            = r_traped;
  assign mret              = w_take_mret;
  assign ecp               = r_ecp;
  assign retired           = w_idle & wb_valid & ~wb_exception;
  assign stall             = ~w_idle;
  assign flush             = w_take_exc | w_take_mret | w_take_irq;
  assign redirect_valid    = r_trap_redir | w_take_mret;
  assign redirect_target   = w_take_mret ? mret_vector : r_redirect_target;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed spec scenarios, a mid-sequence reset,
// then randomized events compared against a transaction-level reference model.
module tb_trap_sequencer;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
`ifdef TRAP_VECTORED_EN
  localparam bit VECTORED = 1'b1;
`else
  localparam bit VECTORED = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_next_pc;
  logic        wb_exception;
  logic [3:0]  wb_cause;
  logic [31:0] wb_tval;
  logic        wb_mret;
  logic        eip, tip, sip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        traped;
  logic        mret;
  logic [31:0] ecp;
  logic        retired;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelEcp = 32'h0;

  trap_sequencer #(.RESET_VECTOR(RESET_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
    .wb_exception(wb_exception), .wb_cause(wb_cause), .wb_tval(wb_tval),
    .wb_mret(wb_mret), .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
    .csr_write_data(csr_write_data), .traped(traped), .mret(mret), .ecp(ecp),
    .retired(retired), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    wb_valid = 0; wb_pc = 0; wb_next_pc = 0; wb_exception = 0; wb_cause = 0;
    wb_tval = 0; wb_mret = 0; eip = 0; tip = 0; sip = 0;
  endtask

  // Noise on writeback/interrupt inputs while a sequence runs; the DUT must ignore it.
  task automatic applyNoise();
    wb_valid = 1'b1; wb_pc = $urandom; wb_next_pc = $urandom;
    wb_exception = 1'($urandom); wb_cause = 4'($urandom); wb_tval = $urandom;
    wb_mret = 1'($urandom); eip = 1'($urandom); tip = 1'($urandom); sip = 1'($urandom);
  endtask

  task automatic applyStimulus(input logic v, input logic ex, input logic [3:0] cs,
                               input logic [31:0] tv, input logic [31:0] pc,
                               input logic [31:0] npc, input logic mr,
                               input logic e, input logic t, input logic s,
                               input logic [31:0] tvec, input logic [31:0] mvec);
    wb_valid = v; wb_exception = ex; wb_cause = cs; wb_tval = tv; wb_pc = pc;
    wb_next_pc = npc; wb_mret = mr; eip = e; tip = t; sip = s;
    trap_vector = tvec; mret_vector = mvec;
  endtask

  // One writeback event presented in IDLE, then the full expected trap sequence if any.
  task automatic doEvent(input logic v, input logic ex, input logic [3:0] cs,
                         input logic [31:0] tv, input logic [31:0] pc,
                         input logic [31:0] npc, input logic mr,
                         input logic e, input logic t, input logic s,
                         input logic [31:0] tvec, input logic [31:0] mvec);
    bit isExc, isMret, isIrq, isTrap;
    logic [31:0] expCause, expTval, expEpc, expTarget, base;
    logic [31:0] writes [3];
    isExc  = v && ex;
    isMret = v && !ex && mr;
    isIrq  = v && !ex && !mr && (e || t || s);
    isTrap = isExc || isIrq;
    expCause = isExc ? 32'(cs) : (e ? 32'h8000_000B : (s ? 32'h8000_0003 : 32'h8000_0007));
    expTval  = isExc ? tv : 32'h0;
    expEpc   = isExc ? pc : npc;
    base     = tvec & 32'hFFFF_FFFC;
    expTarget = (VECTORED && isIrq && (tvec % 4 == 1)) ? base + 4 * (expCause % 16) : base;
    writes[0] = expEpc; writes[1] = expCause; writes[2] = expTval;

    @(posedge clk); #1;
    applyStimulus(v, ex, cs, tv, pc, npc, mr, e, t, s, tvec, mvec);
    #1;
    checkOutput("idle.retired", retired, v && !ex);
    checkOutput("idle.flush", flush, isTrap || isMret);
    checkOutput("idle.mret", mret, isMret);
    checkOutput("idle.redirect_valid", redirect_valid, isMret);
    if (isMret) checkOutput("idle.redirect_target", redirect_target, mvec);
    checkOutput("idle.stall", stall, 0);
    checkOutput("idle.csr_we", csr_write_enable, 0);
    checkOutput("idle.traped", traped, 0);
    checkOutput("idle.ecp", ecp, modelEcp);
    if (!isTrap) return;

    modelEcp = expEpc;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      applyNoise();
      #1;
      checkOutput("seq.csr_we", csr_write_enable, 1);
      checkOutput("seq.csr_addr", csr_write_address, 32'h341 + k);
      checkOutput("seq.csr_data", csr_write_data, writes[k]);
      checkOutput("seq.stall", stall, 1);
      checkOutput("seq.traped", traped, 0);
      checkOutput("seq.redirect_valid", redirect_valid, 0);
      checkOutput("seq.retired", retired, 0);
      checkOutput("seq.flush", flush, 0);
      checkOutput("seq.mret", mret, 0);
    end
    checkOutput("seq.ecp", ecp, expEpc);
    @(posedge clk); #1;
    applyNoise();
    #1;
    checkOutput("redir.traped", traped, 1);
    checkOutput("redir.redirect_valid", redirect_valid, 1);
    checkOutput("redir.redirect_target", redirect_target, expTarget);
    checkOutput("redir.stall", stall, 1);
    checkOutput("redir.csr_we", csr_write_enable, 0);
    checkOutput("redir.mret", mret, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    trap_vector = 32'h200; mret_vector = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.stall", stall, 0);
    checkOutput("reset.csr_we", csr_write_enable, 0);
    checkOutput("reset.traped", traped, 0);
    checkOutput("reset.redirect_valid", redirect_valid, 0);
    checkOutput("reset.redirect_target", redirect_target, RESET_VECTOR);
    checkOutput("reset.ecp", ecp, 0);
    rst_n = 1'b1;

    $display("[TB] directed scenarios");
    doEvent(1, 1, 4'd2, 32'hDEAD, 32'h100, 32'h104, 0, 0, 0, 0, 32'h200, 32'h0);
    doEvent(1, 0, 4'd0, 32'h0, 32'h180, 32'h184, 1, 0, 0, 0, 32'h200, 32'h344);
    doEvent(1, 0, 4'd0, 32'h0, 32'h100, 32'h104, 0, 1, 1, 0, 32'h200, 32'h0);
    doEvent(1, 1, 4'd5, 32'h77, 32'h300, 32'h304, 1, 0, 0, 1, 32'h200, 32'h344);
    doEvent(1, 0, 4'd0, 32'h0, 32'h400, 32'h404, 0, 0, 1, 0, 32'h201, 32'h0);
    doEvent(0, 1, 4'd1, 32'h1, 32'h500, 32'h504, 1, 1, 1, 1, 32'h200, 32'h600);
    doEvent(1, 0, 4'd0, 32'h0, 32'h700, 32'h704, 0, 1, 1, 1, 32'h201, 32'h0);
    doEvent(1, 0, 4'd0, 32'h0, 32'h800, 32'h804, 0, 0, 0, 1, 32'h201, 32'h0);

    $display("[TB] reset during W_CAUSE");
    @(posedge clk); #1;
    applyStimulus(1, 1, 4'd3, 32'hBEEF, 32'h900, 32'h904, 0, 0, 0, 0, 32'h200, 32'h0);
    @(posedge clk); #1;
    clearInputs();
    @(posedge clk); #1;
    checkOutput("abort.pre_addr", csr_write_address, 32'h342);
    rst_n = 1'b0;
    #1;
    modelEcp = 32'h0;
    checkOutput("abort.stall", stall, 0);
    checkOutput("abort.csr_we", csr_write_enable, 0);
    checkOutput("abort.ecp", ecp, 0);
    checkOutput("abort.redirect_target", redirect_target, RESET_VECTOR);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      checkOutput("abort.csr_we_after", csr_write_enable, 0);
      checkOutput("abort.traped_after", traped, 0);
      checkOutput("abort.stall_after", stall, 0);
      checkOutput("abort.redirect_valid_after", redirect_valid, 0);
    end

    $display("[TB] randomized events");
    for (int n = 0; n < 300; n++) begin
      doEvent(($urandom % 4) != 0, ($urandom % 4) == 0, 4'($urandom), $urandom,
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, ($urandom % 5) == 0,
              ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
              $urandom, $urandom & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
